// File: rtl/ps2_key_tracker_pkg.sv
// Shared scan-code constants, FSM/move encodings and the scan-code-to-key map
// used by the PS/2 key tracker and the display logic that consumes move codes.
package ps2_key_tracker_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_FAIL  = 8'hFC;
    localparam logic [7:0] SC_ACK   = 8'hFA;
    localparam logic [7:0] SC_ECHO  = 8'hEE;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MV_STOP  = 2'b00,
        MV_LEFT  = 2'b01,
        MV_RIGHT = 2'b10
    } move_e;

    typedef struct packed {
        logic left;
        logic right;
        logic fire;
        logic start;
    } keys_t;

    // Arrows only count when E0-prefixed; A/D/space only when not; enter either way.
    function automatic keys_t key_map(input logic [7:0] code, input logic ext);
        keys_t hit;
        hit       = '0;
        hit.left  = ext ? (code == SC_LEFT)  : (code == SC_A);
        hit.right = ext ? (code == SC_RIGHT) : (code == SC_D);
        hit.fire  = ~ext & (code == SC_SPACE);
        hit.start = (code == SC_ENTER);
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_key_edge_pulse.sv
// Registered level-to-rising-edge converter: the pulse appears on the same
// cycle as the registered level rises, for exactly one cycle.
module key_edge_pulse (
    input  logic clk_in,
    input  logic reset,
    input  logic level_d_i,
    output logic pulse_o
);

    logic level_q;
    logic pulse_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d_i;
            pulse_q <= level_d_i & ~level_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 Set 2 scan-code bytes into held game-control levels, press
// pulses and a resolved paddle direction (last-pressed wins).
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2500000,
    parameter int TO_W        = 22
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_vld,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic       key_start,
    output logic       fire_pulse,
    output logic       start_pulse,
    output logic [1:0] move,
    output logic [7:0] last_code
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    keys_t           keys_q, keys_d;
    move_e           move_q, move_d;
    logic [7:0]      code_q, code_d;

    logic  is_code_s;
    logic  ext_s;
    logic  brk_s;
    logic  special_clr_s;
    logic  ignored_s;
    keys_t hit_s;

    assign special_clr_s = (ps2_byte == SC_BAT) || (ps2_byte == SC_FAIL);
    assign ignored_s     = (ps2_byte == SC_ACK) || (ps2_byte == SC_ECHO) ||
                           (ps2_byte == SC_ERR0) || (ps2_byte == SC_ERR1);

    // Prefix FSM, timeout counter and key/direction next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        keys_d    = keys_q;
        move_d    = move_q;
        code_d    = code_q;
        is_code_s = 1'b0;
        ext_s     = 1'b0;
        brk_s     = 1'b0;

        if (ps2_byte_vld) begin
            cnt_d = '0;
            if (special_clr_s) begin
                keys_d  = '0;
                move_d  = MV_STOP;
                state_d = ST_IDLE;
            end else if (ignored_s) begin
                state_d = state_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ps2_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (ps2_byte == SC_BRK) begin
                            state_d = ST_BRK;
                        end else begin
                            is_code_s = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (ps2_byte == SC_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else if (ps2_byte == SC_EXT) begin
                            state_d = ST_EXT;
                        end else begin
                            is_code_s = 1'b1;
                            ext_s     = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        state_d = ST_IDLE;
                        if ((ps2_byte != SC_EXT) && (ps2_byte != SC_BRK)) begin
                            is_code_s = 1'b1;
                            brk_s     = 1'b1;
                        end else begin
                            is_code_s = 1'b0;
                        end
                    end
                    ST_EXT_BRK: begin
                        state_d = ST_IDLE;
                        if ((ps2_byte != SC_EXT) && (ps2_byte != SC_BRK)) begin
                            is_code_s = 1'b1;
                            ext_s     = 1'b1;
                            brk_s     = 1'b1;
                        end else begin
                            is_code_s = 1'b0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == TO_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TO_ONE;
            end
        end else begin
            cnt_d = '0;
        end

        hit_s = key_map(ps2_byte, ext_s);

        if (is_code_s) begin
            code_d = ps2_byte;
            if (brk_s) begin
                keys_d = keys_q & ~hit_s;
                // Releasing the active direction falls back to the other key if still held.
                if (hit_s.left && (move_q == MV_LEFT)) begin
                    move_d = keys_q.right ? MV_RIGHT : MV_STOP;
                end else if (hit_s.right && (move_q == MV_RIGHT)) begin
                    move_d = keys_q.left ? MV_LEFT : MV_STOP;
                end else begin
                    move_d = move_q;
                end
            end else begin
                keys_d = keys_q | hit_s;
                if (hit_s.left) begin
                    move_d = MV_LEFT;
                end else if (hit_s.right) begin
                    move_d = MV_RIGHT;
                end else begin
                    move_d = move_q;
                end
            end
        end else begin
            code_d = code_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            keys_q  <= '0;
            move_q  <= MV_STOP;
            code_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keys_q  <= keys_d;
            move_q  <= move_d;
            code_q  <= code_d;
        end
    end

    key_edge_pulse u_fire_pulse (
        .clk_in    (clk_in),
        .reset     (reset),
        .level_d_i (keys_d.fire),
        .pulse_o   (fire_pulse)
    );

    key_edge_pulse u_start_pulse (
        .clk_in    (clk_in),
        .reset     (reset),
        .level_d_i (keys_d.start),
        .pulse_o   (start_pulse)
    );

    assign key_left  = keys_q.left;
    assign key_right = keys_q.right;
    assign key_fire  = keys_q.fire;
    assign key_start = keys_q.start;
    assign move      = move_q;
    assign last_code = code_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench: the driver pushes the model's expected outputs per strobe
// or reset cycle; a negedge monitor pops them and checks every cycle.
module tb_ps2_key_tracker;

    localparam int TO = 16;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_vld = 1'b0;
    logic       key_left, key_right, key_fire, key_start;
    logic       fire_pulse, start_pulse;
    logic [1:0] move;
    logic [7:0] last_code;

    ps2_key_tracker #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .ps2_byte     (ps2_byte),
        .ps2_byte_vld (ps2_byte_vld),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_fire     (key_fire),
        .key_start    (key_start),
        .fire_pulse   (fire_pulse),
        .start_pulse  (start_pulse),
        .move         (move),
        .last_code    (last_code)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       kl, kr, kf, ks, fp, sp;
        logic [1:0] mv;
        logic [7:0] lc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: keyboard state as described by make/break/prefix rules.
    bit       ml, mr, mf, ms, mfp, msp;
    bit [1:0] mmv;
    bit [7:0] mlc;
    bit       pend_ext, pend_brk;
    int       last_t;
    int       cyc = 0;

    function automatic void model_reset();
        {ml, mr, mf, ms, mfp, msp} = 6'b0;
        mmv = 2'b00; mlc = 8'h00;
        pend_ext = 1'b0; pend_brk = 1'b0;
    endfunction

    function automatic void model_byte(input bit [7:0] b, input int t);
        bit ext, mk, is_l, is_r, is_f, is_s;
        mfp = 1'b0; msp = 1'b0;
        if ((pend_ext || pend_brk) && (t - last_t > TO)) begin
            pend_ext = 1'b0; pend_brk = 1'b0;
        end
        last_t = t;
        if (b == 8'hAA || b == 8'hFC) begin
            {ml, mr, mf, ms} = 4'b0; mmv = 2'b00;
            pend_ext = 1'b0; pend_brk = 1'b0;
        end else if (b == 8'hFA || b == 8'hEE || b == 8'h00 || b == 8'hFF) begin
            ext = 1'b0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (pend_brk) begin
                pend_ext = 1'b0; pend_brk = 1'b0;
            end else if (b == 8'hE0) begin
                pend_ext = 1'b1;
            end else begin
                pend_brk = 1'b1;
            end
        end else begin
            ext = pend_ext; mk = !pend_brk;
            pend_ext = 1'b0; pend_brk = 1'b0;
            mlc = b;
            is_l = ext ? (b == 8'h6B) : (b == 8'h1C);
            is_r = ext ? (b == 8'h74) : (b == 8'h23);
            is_f = !ext && (b == 8'h29);
            is_s = (b == 8'h5A);
            if (mk) begin
                if (is_f && !mf) mfp = 1'b1;
                if (is_s && !ms) msp = 1'b1;
                if (is_l) begin ml = 1'b1; mmv = 2'b01; end
                if (is_r) begin mr = 1'b1; mmv = 2'b10; end
                if (is_f) mf = 1'b1;
                if (is_s) ms = 1'b1;
            end else begin
                if (is_l) begin ml = 1'b0; if (mmv == 2'b01) mmv = mr ? 2'b10 : 2'b00; end
                if (is_r) begin mr = 1'b0; if (mmv == 2'b10) mmv = ml ? 2'b01 : 2'b00; end
                if (is_f) mf = 1'b0;
                if (is_s) ms = 1'b0;
            end
        end
    endfunction

    task automatic step(input bit v, input bit [7:0] b, input bit r);
        exp_t e;
        @(negedge clk_in);
        ps2_byte_vld = v;
        ps2_byte     = b;
        reset        = r;
        if (r) model_reset();
        else if (v) model_byte(b, cyc);
        if (r || v) begin
            e = '{kl: ml, kr: mr, kf: mf, ks: ms, fp: mfp, sp: msp, mv: mmv, lc: mlc};
            sb_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input bit [7:0] b, input int gap);
        step(1'b1, b, 1'b0);
        idle(gap);
    endtask

    // Monitor: an expectation becomes current the cycle after its strobe/reset.
    logic pop_pending = 1'b0;
    logic started = 1'b0;
    exp_t cur;

    always @(posedge clk_in) pop_pending <= ps2_byte_vld | reset;

    always @(negedge clk_in) begin
        exp_t got;
        if (pop_pending) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow at t=%0t: no expectation queued, required one", $time);
            end else begin
                cur = sb_q.pop_front();
                started = 1'b1;
            end
        end else begin
            cur.fp = 1'b0;
            cur.sp = 1'b0;
        end
        if (started) begin
            got = '{kl: key_left, kr: key_right, kf: key_fire, ks: key_start,
                    fp: fire_pulse, sp: start_pulse, mv: move, lc: last_code};
            checks++;
            if (got !== cur) begin
                errors++;
                $display("FAIL outputs t=%0t got L%b R%b F%b S%b fp%b sp%b mv%b lc%h required L%b R%b F%b S%b fp%b sp%b mv%b lc%h",
                         $time, got.kl, got.kr, got.kf, got.ks, got.fp, got.sp, got.mv, got.lc,
                         cur.kl, cur.kr, cur.kf, cur.ks, cur.fp, cur.sp, cur.mv, cur.lc);
            end
        end
    end

    bit [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h29,
                            8'h5A, 8'hAA, 8'hFC, 8'hFA, 8'h00, 8'h12, 8'hE0};

    initial begin
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(2);
        // Extended left make then break
        send(8'hE0, 10); send(8'h6B, 10);
        send(8'hE0, 10); send(8'hF0, 10); send(8'h6B, 10);
        // Last-pressed-wins direction
        send(8'h1C, 3); send(8'hE0, 0); send(8'h74, 3);
        send(8'hF0, 0); send(8'hE0, 0); send(8'h74, 3);
        send(8'hF0, 1); send(8'h1C, 3);
        // Typematic fire
        send(8'h29, 2); send(8'h29, 2); send(8'h29, 2);
        send(8'hF0, 1); send(8'h29, 4);
        // Prefix abandoned after timeout, and byte arriving on the timeout cycle
        send(8'hE0, TO); send(8'h6B, 3);
        send(8'hF0, 0); send(8'h6B, 3);
        send(8'hE0, TO - 1); send(8'h6B, 3);
        send(8'hE0, 0); send(8'hF0, TO - 1); send(8'h6B, 3);
        // Self-test clears held keys
        send(8'h1C, 1); send(8'h5A, 1); send(8'hE0, 0); send(8'h5A, 1);
        send(8'hFA, 1); send(8'hAA, 3);
        // Reset mid-sequence discards pending break prefix
        send(8'hF0, 0);
        step(1'b0, 8'h00, 1'b1);
        send(8'h23, 3);
        send(8'hF0, 0); send(8'h23, 2);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int gap;
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
            send(pool[$urandom_range(0, 13)], gap);
        end
        idle(4);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
